// File: rtl/tron_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tron_game_ctrl_pkg
// Brief   : Shared codes and state encoding for the light-cycle game controller
// Revision: 1.0 - initial release
// ============================================================================
package tron_game_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [2:0] COL_CLEAR = 3'b000;
  localparam logic [2:0] COL_P1    = 3'b100;
  localparam logic [2:0] COL_P2    = 3'b001;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam int KEY_START  = 5;
  localparam int KEY_PLAYER = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_INIT      = 4'd2,
    ST_WAIT_TICK = 4'd3,
    ST_RD1       = 4'd4,
    ST_RD2       = 4'd5,
    ST_EVAL      = 4'd6,
    ST_WR1       = 4'd7,
    ST_WR2       = 4'd8,
    ST_OVER      = 4'd9
  } state_e;

  // Opposite heading differs only in the upper bit of the direction code.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tron_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : tron_game_ctrl_if
// Brief   : Pixel-plot req/ack channel from the game controller to the display
// Revision: 1.0 - initial release
// ============================================================================
interface tron_game_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic          plot_req;
  logic          plot_ack;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [2:0]    plot_colour;

  modport master (output plot_req, plot_x, plot_y, plot_colour, input plot_ack);
  modport slave  (input plot_req, plot_x, plot_y, plot_colour, output plot_ack);
endinterface
`default_nettype wire

// File: rtl/tron_game_ctrl_grid_ram.sv
`default_nettype none
// ============================================================================
// Module  : tron_game_ctrl_grid_ram
// Brief   : 1-bit trail-occupancy RAM, one sync read + one write port
// Revision: 1.0 - initial release
// ============================================================================
module tron_game_ctrl_grid_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic mem [DEPTH];

  // Read-during-write to the same cell returns the previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/tron_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tron_game_ctrl
// Brief   : Two-player light-cycle mechanics: grid, movement, crashes, plotting
// Revision: 1.0 - initial release
// ============================================================================
module tron_game_ctrl
  import tron_game_ctrl_pkg::*;
#(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int XW     = 6,
  parameter int YW     = 5
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                key_valid,
  input  logic [5:0]          key_code,
  input  logic                tick,
  tron_game_ctrl_if.master    plot,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic                busy
);
  localparam int AW = $clog2(GRID_W * GRID_H);
  localparam int CW = XW + YW + 1;

  state_e          state_q, state_d;
  logic [XW-1:0]   p1x_q, p2x_q, nx1_q, nx2_q, cx_q, px_q;
  logic [YW-1:0]   p1y_q, p2y_q, ny1_q, ny2_q, cy_q, py_q;
  logic [1:0]      dir1_q, dir2_q, pend1_q, pend2_q, winner_q, base1, base2;
  logic [2:0]      colour_q;
  logic            wall1_q, wall2_q, occ1_q, req_q;
  logic [CW-1:0]   n1, n2;
  logic            rd_en, rd_data, wr_en, wr_data;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic            start_key, dir_key, last_cell, head_on, crash1, crash2, acked;
  logic            unused_key_bits;

  // Returns {wall, x, y}; on a wall hit the coordinates are left unchanged.
  function automatic logic [CW-1:0] next_cell(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                              input logic [1:0] d);
    logic          wall;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    wall = 1'b0;
    nx   = x;
    ny   = y;
    case (d)
      DIR_UP:   if (y == '0) wall = 1'b1; else ny = y - 1'b1;
      DIR_DOWN: if (y == YW'(GRID_H - 1)) wall = 1'b1; else ny = y + 1'b1;
      DIR_LEFT: if (x == '0) wall = 1'b1; else nx = x - 1'b1;
      default:  if (x == XW'(GRID_W - 1)) wall = 1'b1; else nx = x + 1'b1;
    endcase
    return {wall, nx, ny};
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  assign n1              = next_cell(p1x_q, p1y_q, dir1_q);
  assign n2              = next_cell(p2x_q, p2y_q, dir2_q);
  assign start_key       = key_valid & key_code[KEY_START];
  assign dir_key         = key_valid & ~key_code[KEY_START] &
                           (state_q != ST_IDLE) & (state_q != ST_CLEAR);
  assign last_cell       = (cx_q == XW'(GRID_W - 1)) && (cy_q == YW'(GRID_H - 1));
  assign head_on         = ~wall1_q & ~wall2_q & (nx1_q == nx2_q) & (ny1_q == ny2_q);
  assign crash1          = wall1_q | occ1_q | head_on;
  assign crash2          = wall2_q | (rd_data & ~wall2_q) | head_on;
  assign acked           = req_q & plot.plot_ack;
  assign base1           = (state_q == ST_INIT) ? DIR_RIGHT : dir1_q;
  assign base2           = (state_q == ST_INIT) ? DIR_LEFT  : dir2_q;
  assign unused_key_bits = ^key_code[3:2];

  assign plot.plot_req    = req_q;
  assign plot.plot_x      = px_q;
  assign plot.plot_y      = py_q;
  assign plot.plot_colour = colour_q;
  assign game_over        = (state_q == ST_OVER);
  assign winner           = winner_q;
  assign busy             = (state_q != ST_IDLE) && (state_q != ST_WAIT_TICK) && (state_q != ST_OVER);

  tron_game_ctrl_grid_ram #(.DEPTH(GRID_W * GRID_H), .AW(AW)) u_grid (
    .clk(CLOCK_50), .we(wr_en), .waddr(wr_addr), .wdata(wr_data),
    .re(rd_en), .raddr(rd_addr), .rdata(rd_data)
  );

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 1'b0;
    case (state_q)
      ST_RD1: begin rd_en = ~n1[CW-1]; rd_addr = cell_addr(n1[CW-2:YW], n1[YW-1:0]); end
      ST_RD2: begin rd_en = ~wall2_q;  rd_addr = cell_addr(nx2_q, ny2_q); end
      ST_CLEAR: begin wr_en = ~req_q; wr_addr = cell_addr(cx_q, cy_q); end
      ST_WR1: begin wr_en = ~req_q; wr_addr = cell_addr(nx1_q, ny1_q); wr_data = 1'b1; end
      ST_WR2: begin wr_en = ~req_q; wr_addr = cell_addr(nx2_q, ny2_q); wr_data = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_key) state_d = ST_CLEAR;
      ST_CLEAR:     if (acked && last_cell) state_d = ST_INIT;
      ST_INIT:      state_d = ST_WR1;
      ST_WAIT_TICK: if (tick) state_d = ST_RD1;
      ST_RD1:       state_d = ST_RD2;
      ST_RD2:       state_d = ST_EVAL;
      ST_EVAL:      state_d = (crash1 | crash2) ? ST_OVER : ST_WR1;
      ST_WR1:       if (acked) state_d = ST_WR2;
      ST_WR2:       if (acked) state_d = ST_WAIT_TICK;
      ST_OVER:      if (start_key) state_d = ST_CLEAR;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      {p1x_q, p1y_q, p2x_q, p2y_q, nx1_q, ny1_q, nx2_q, ny2_q} <= '0;
      {cx_q, cy_q, px_q, py_q, colour_q, req_q}                <= '0;
      {dir1_q, dir2_q, pend1_q, pend2_q, winner_q}             <= '0;
      {wall1_q, wall2_q, occ1_q}                               <= '0;
    end else begin
      if (state_q != ST_CLEAR) begin
        cx_q <= '0;
        cy_q <= '0;
      end
      // Each plotting state loads its cell while idle, then waits for the ack.
      case (state_q)
        ST_CLEAR: begin
          if (!req_q) begin
            px_q <= cx_q; py_q <= cy_q; colour_q <= COL_CLEAR; req_q <= 1'b1;
          end else if (plot.plot_ack) begin
            req_q <= 1'b0;
            if (cx_q == XW'(GRID_W - 1)) begin
              cx_q <= '0;
              cy_q <= cy_q + 1'b1;
            end else begin
              cx_q <= cx_q + 1'b1;
            end
          end
        end
        ST_INIT: begin
          nx1_q  <= XW'(GRID_W / 4);     ny1_q <= YW'(GRID_H / 2);
          nx2_q  <= XW'(3 * GRID_W / 4); ny2_q <= YW'(GRID_H / 2);
          dir1_q <= DIR_RIGHT;           dir2_q <= DIR_LEFT;
        end
        ST_WAIT_TICK: if (tick) begin dir1_q <= pend1_q; dir2_q <= pend2_q; end
        ST_RD1: begin
          {wall1_q, nx1_q, ny1_q} <= n1;
          {wall2_q, nx2_q, ny2_q} <= n2;
        end
        ST_RD2: occ1_q <= rd_data & ~wall1_q;
        ST_EVAL: begin
          if (crash1 && crash2) winner_q <= WIN_DRAW;
          else if (crash1)      winner_q <= WIN_P2;
          else if (crash2)      winner_q <= WIN_P1;
        end
        ST_WR1: begin
          if (!req_q) begin
            p1x_q <= nx1_q; p1y_q <= ny1_q;
            px_q <= nx1_q; py_q <= ny1_q; colour_q <= COL_P1; req_q <= 1'b1;
          end else if (plot.plot_ack) begin
            req_q <= 1'b0;
          end
        end
        ST_WR2: begin
          if (!req_q) begin
            p2x_q <= nx2_q; p2y_q <= ny2_q;
            px_q <= nx2_q; py_q <= ny2_q; colour_q <= COL_P2; req_q <= 1'b1;
          end else if (plot.plot_ack) begin
            req_q <= 1'b0;
          end
        end
        ST_OVER: if (start_key) winner_q <= WIN_NONE;
        default: ;
      endcase

      if (state_q == ST_INIT) begin
        pend1_q <= DIR_RIGHT;
        pend2_q <= DIR_LEFT;
      end
      if (dir_key && !key_code[KEY_PLAYER] && (key_code[1:0] != dir_reverse(base1)))
        pend1_q <= key_code[1:0];
      if (dir_key && key_code[KEY_PLAYER] && (key_code[1:0] != dir_reverse(base2)))
        pend2_q <= key_code[1:0];
    end
  end
endmodule
`default_nettype wire
